// File: rtl/sfx_scheduler.sv
// Sound-effect sequencer/arbiter: latches request pulses, plays one effect's note table at a time.
// Optional SFX_PREEMPT_EN lets a pending game-over abort any other effect in progress.
module sfx_scheduler #(
  parameter int NOTE_CYCLES = 5_000_000,
  parameter int GAP_CYCLES  = 1_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_hit,
  input  logic       req_miss,
  input  logic       req_start,
  input  logic       req_over,
  input  logic       en_music,
  output logic [4:0] tone,
  output logic       tone_valid,
  output logic       music_en_out,
  output logic       busy,
  output logic [1:0] active_id
);

  localparam int MAX_CYC = (NOTE_CYCLES > GAP_CYCLES) ? NOTE_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [CNT_W-1:0] NOTE_LAST = CNT_W'(NOTE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;

  state_t           state;
  logic [3:0]       pending;
  logic [3:0]       grant;
  logic [1:0]       idx;
  logic [CNT_W-1:0] cnt;
  logic             busy_next;
  logic             preempt;

  function automatic logic [4:0] note_code(input logic [1:0] id, input logic [1:0] i);
    case ({id, i})
      4'b00_00: note_code = 5'd20;
      4'b00_01: note_code = 5'd24;
      4'b01_00: note_code = 5'd12;
      4'b01_01: note_code = 5'd8;
      4'b01_10: note_code = 5'd4;
      4'b10_00: note_code = 5'd12;
      4'b10_01: note_code = 5'd16;
      4'b10_10: note_code = 5'd19;
      4'b10_11: note_code = 5'd24;
      4'b11_00: note_code = 5'd24;
      4'b11_01: note_code = 5'd19;
      4'b11_10: note_code = 5'd16;
      4'b11_11: note_code = 5'd12;
      default:  note_code = 5'd0;
    endcase
  endfunction

  function automatic logic [1:0] last_idx(input logic [1:0] id);
    case (id)
      2'd0:    last_idx = 2'd1;
      2'd1:    last_idx = 2'd2;
      default: last_idx = 2'd3;
    endcase
  endfunction

  // Fixed priority: over > start > miss > hit
  function automatic logic [1:0] pick(input logic [3:0] p);
    if (p[3])      pick = 2'd3;
    else if (p[2]) pick = 2'd2;
    else if (p[1]) pick = 2'd1;
    else           pick = 2'd0;
  endfunction

  always_comb begin
`ifdef SFX_PREEMPT_EN
    preempt = (state != IDLE) && (active_id != 2'd3) && pending[3];
`else
    preempt = 1'b0;
`endif
    grant     = '0;
    busy_next = busy;
    if (state == IDLE && pending != 4'd0) begin
      grant[pick(pending)] = 1'b1;
      busy_next            = 1'b1;
    end
    if (state == GAP && cnt == GAP_LAST && idx == last_idx(active_id))
      busy_next = 1'b0;
    if (preempt) begin
      grant     = 4'b1000;
      busy_next = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      pending      <= '0;
      idx          <= '0;
      cnt          <= '0;
      tone         <= '0;
      tone_valid   <= 1'b0;
      busy         <= 1'b0;
      active_id    <= '0;
      music_en_out <= 1'b0;
    end else begin
      // A request on the grant edge re-arms the bit after it is cleared
      pending      <= (pending & ~grant) | {req_over, req_start, req_miss, req_hit};
      busy         <= busy_next;
      music_en_out <= en_music & ~busy_next;
      if (preempt) begin
        active_id  <= 2'd3;
        idx        <= '0;
        cnt        <= '0;
        state      <= PLAY;
        tone       <= note_code(2'd3, 2'd0);
        tone_valid <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            if (pending != 4'd0) begin
              active_id  <= pick(pending);
              idx        <= '0;
              cnt        <= '0;
              state      <= PLAY;
              tone       <= note_code(pick(pending), 2'd0);
              tone_valid <= 1'b1;
            end
          end
          PLAY: begin
            if (cnt == NOTE_LAST) begin
              cnt        <= '0;
              state      <= GAP;
              tone       <= '0;
              tone_valid <= 1'b0;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          GAP: begin
            if (cnt == GAP_LAST) begin
              cnt <= '0;
              if (idx == last_idx(active_id)) begin
                state     <= IDLE;
                active_id <= '0;
              end else begin
                idx        <= idx + 2'd1;
                state      <= PLAY;
                tone       <= note_code(active_id, idx + 2'd1);
                tone_valid <= 1'b1;
              end
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sfx_scheduler.sv
// Self-checking bench for sfx_scheduler: time-based effect model checked every cycle plus directed sequences.
module tb_sfx_scheduler;
  localparam int N = 4;
  localparam int G = 2;
  localparam int P = N + G;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req_hit = 1'b0, req_miss = 1'b0, req_start = 1'b0, req_over = 1'b0;
  logic en_music = 1'b0;
  logic [4:0] tone;
  logic tone_valid, music_en_out, busy;
  logic [1:0] active_id;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  sfx_scheduler #(.NOTE_CYCLES(N), .GAP_CYCLES(G)) dut (
    .clk(clk), .rst(rst), .req_hit(req_hit), .req_miss(req_miss),
    .req_start(req_start), .req_over(req_over), .en_music(en_music),
    .tone(tone), .tone_valid(tone_valid), .music_en_out(music_en_out),
    .busy(busy), .active_id(active_id)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
  endtask

  function automatic int note_of(input int id, input int k);
    case (id * 4 + k)
      0: return 20;  1: return 24;
      4: return 12;  5: return 8;   6: return 4;
      8: return 12;  9: return 16;  10: return 19; 11: return 24;
      12: return 24; 13: return 19; 14: return 16; 15: return 12;
      default: return 0;
    endcase
  endfunction

  function automatic int len_of(input int id);
    return (id == 0) ? 2 : (id == 1) ? 3 : 4;
  endfunction

  // Model: which effect is playing and how many cycles since its grant
  logic [3:0] m_pend = '0;
  logic       m_busy = 1'b0;
  int         m_id   = 0;
  int         m_t    = 0;
  logic       m_men  = 1'b0;

  initial begin
    logic [3:0] rq;
    logic       pre;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_pend = '0; m_busy = 1'b0; m_id = 0; m_t = 0; m_men = 1'b0;
      end else begin
        rq  = {req_over, req_start, req_miss, req_hit};
        pre = 1'b0;
`ifdef SFX_PREEMPT_EN
        if (m_busy && m_id != 3 && m_pend[3]) begin
          m_id = 3; m_t = 0; m_pend[3] = 1'b0; pre = 1'b1;
        end
`endif
        if (!pre) begin
          if (m_busy) begin
            m_t++;
            if (m_t == len_of(m_id) * P) begin
              m_busy = 1'b0; m_id = 0; m_t = 0;
            end
          end else if (m_pend != 4'd0) begin
            m_id = m_pend[3] ? 3 : m_pend[2] ? 2 : m_pend[1] ? 1 : 0;
            m_pend[m_id] = 1'b0;
            m_busy = 1'b1;
            m_t = 0;
          end
        end
        m_pend = m_pend | rq;
        m_men  = en_music & ~m_busy;
      end
    end
  end

  initial begin
    logic [4:0] et;
    logic       ev;
    forever begin
      @(negedge clk);
      if (!rst) begin
        ev = m_busy && ((m_t % P) < N);
        et = ev ? 5'(note_of(m_id, m_t / P)) : 5'd0;
        check("cycle", {54'd0, tone, tone_valid, busy, active_id, music_en_out},
              {54'd0, et, ev, m_busy, 2'(m_id), m_men});
      end
    end
  end

  // Observation log: note onsets, active_id changes, busy and music-low cycle counts
  logic [63:0] note_log = '0;
  logic [63:0] id_log   = '0;
  int note_n = 0, id_n = 0, busy_cyc = 0, men_low = 0;

  initial begin
    logic pv, pb;
    logic [4:0] pt;
    logic [1:0] pid;
    pv = 1'b0; pb = 1'b0; pt = '0; pid = '0;
    forever begin
      @(negedge clk);
      if (tone_valid && (!pv || tone != pt)) begin
        note_log = {note_log[58:0], tone}; note_n++;
      end
      if (busy && (!pb || active_id != pid)) begin
        id_log = {id_log[61:0], active_id}; id_n++;
      end
      if (busy) busy_cyc++;
      if (!music_en_out) men_low++;
      pv = tone_valid; pt = tone; pb = busy; pid = active_id;
    end
  end

  int b_note, b_id, b_busy, b_low;

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic snap();
    b_note = note_n; b_id = id_n; b_busy = busy_cyc; b_low = men_low;
  endtask

  task automatic pulse(input logic [3:0] m);
    {req_over, req_start, req_miss, req_hit} = m;
    step();
    {req_over, req_start, req_miss, req_hit} = 4'd0;
  endtask

  task automatic wait_done(input string name);
    bit seen = 0;
    int quiet = 0;
    for (int i = 0; i < 400 && !(seen && quiet >= 3); i++) begin
      step();
      if (busy) begin seen = 1; quiet = 0; end
      else quiet++;
    end
    check({name, "_done"}, {63'd0, seen && quiet >= 3}, 64'd1);
  endtask

  function automatic logic [63:0] tail(input logic [63:0] v, input int bits);
    return (bits >= 64) ? v : (v & ((64'd1 << bits) - 64'd1));
  endfunction

  task automatic check_seq(input string name, input logic [63:0] en, input int nn,
                           input logic [63:0] ei, input int ni, input int eb);
    check({name, "_notes_n"}, 64'(note_n - b_note), 64'(nn));
    check({name, "_notes"}, tail(note_log, 5 * (note_n - b_note)), en);
    check({name, "_ids_n"}, 64'(id_n - b_id), 64'(ni));
    check({name, "_ids"}, tail(id_log, 2 * (id_n - b_id)), ei);
    if (eb >= 0) check({name, "_busy_cyc"}, 64'(busy_cyc - b_busy), 64'(eb));
  endtask

  initial begin
    step(); step(); step();
    check("rst_tone", {59'd0, tone}, 64'd0);
    check("rst_valid", {63'd0, tone_valid}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_id", {62'd0, active_id}, 64'd0);
    rst = 1'b0;
    en_music = 1'b1;
    step(); step();

    // Single hit
    snap();
    pulse(4'b0001);
    wait_done("hit");
    check_seq("hit", {5'd20, 5'd24}, 2, {2'd0}, 1, 12);
    check("hit_music_low", 64'(men_low - b_low), 64'd12);

    // Hit and miss together: miss first
    snap();
    pulse(4'b0011);
    wait_done("hitmiss");
    check_seq("hitmiss", {5'd12, 5'd8, 5'd4, 5'd20, 5'd24}, 5, {2'd1, 2'd0}, 2, 30);

    // Repeated hit pulses during a hit collapse to one replay
    snap();
    pulse(4'b0001);
    step(); step();
    pulse(4'b0001);
    step();
    pulse(4'b0001);
    step(); step(); step();
    pulse(4'b0001);
    wait_done("rehit");
    check_seq("rehit", {5'd20, 5'd24, 5'd20, 5'd24}, 4, {2'd0, 2'd0}, 2, 24);

    // Game over during second note of start
    snap();
    pulse(4'b0100);
    for (int i = 0; i < 40 && tone != 5'd16; i++) step();
    check("over_reach16", {59'd0, tone}, 64'd16);
    pulse(4'b1000);
    wait_done("over");
`ifdef SFX_PREEMPT_EN
    check_seq("over", {5'd12, 5'd16, 5'd24, 5'd19, 5'd16, 5'd12}, 6, {2'd2, 2'd3}, 2, -1);
`else
    check_seq("over", {5'd12, 5'd16, 5'd19, 5'd24, 5'd24, 5'd19, 5'd16, 5'd12}, 8,
              {2'd2, 2'd3}, 2, 48);
`endif

    // Async reset mid-miss with a hit pending
    pulse(4'b0010);
    for (int i = 0; i < 40 && tone != 5'd8; i++) step();
    check("rst_reach8", {59'd0, tone}, 64'd8);
    pulse(4'b0001);
    step();
    #1 rst = 1'b1;
    #1;
    check("arst_tone", {59'd0, tone}, 64'd0);
    check("arst_valid", {63'd0, tone_valid}, 64'd0);
    check("arst_busy", {63'd0, busy}, 64'd0);
    check("arst_id", {62'd0, active_id}, 64'd0);
    step(); step();
    rst = 1'b0;
    snap();
    for (int i = 0; i < 30; i++) step();
    check("arst_no_replay_busy", 64'(busy_cyc - b_busy), 64'd0);
    check("arst_no_replay_notes", 64'(note_n - b_note), 64'd0);

    // Music gating
    en_music = 1'b0; step(); step();
    check("music_off", {63'd0, music_en_out}, 64'd0);
    en_music = 1'b1; step();
    check("music_on", {63'd0, music_en_out}, 64'd1);
    en_music = 1'b0; step();
    check("music_off2", {63'd0, music_en_out}, 64'd0);
    en_music = 1'b1; step();
    check("music_on2", {63'd0, music_en_out}, 64'd1);
    snap();
    pulse(4'b0100);
    wait_done("duck");
    check_seq("duck", {5'd12, 5'd16, 5'd19, 5'd24}, 4, {2'd2}, 1, 24);
    check("duck_music_low", 64'(men_low - b_low), 64'd24);
    check("duck_restored", {63'd0, music_en_out}, 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/sfx_scheduler.md
Name: sfx_scheduler

Overview:
Sequencer and arbiter that shares the single audio tone datapath between the game's sound-effect requesters (hit, miss, round start, game over). It latches one-cycle request pulses, grants one effect at a time by fixed priority, and steps through that effect's note table. Each note is held for a programmable time and followed by a silent gap. While an effect plays it ducks background music. It sits between the game FSM/debounced event pulses and the audio top-level that turns tone codes into I2S samples.

Parameters:
NOTE_CYCLES, 5_000_000, clk cycles each note is held (50 ms at 100 MHz); legal range >= 2
GAP_CYCLES, 1_000_000, clk cycles of silence after each note; legal range >= 1

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
req_hit  in  1  one-cycle pulse: mole hit
req_miss  in  1  one-cycle pulse: miss
req_start  in  1  one-cycle pulse: round start
req_over  in  1  one-cycle pulse: game over
en_music  in  1  background music enable from game FSM
tone  out  5  note code to audio datapath; 0 = silence
tone_valid  out  1  high while a note (not a gap) is sounding
music_en_out  out  1  gated music enable to audio datapath
busy  out  1  high in any state other than IDLE
active_id  out  2  effect being played: 0 hit, 1 miss, 2 start, 3 over (0 when idle)

Behaviour:
- Reset (async, rst=1): state IDLE, all pending bits 0, counters 0, tone=0, tone_valid=0, busy=0, active_id=0. Reset mid-effect aborts immediately; nothing resumes after release.
- Pending latch per requester: set on the clock edge sampling its pulse, cleared on the edge its effect is granted. Repeated pulses while pending collapse to one. A pulse for the currently playing effect sets its pending bit again, so the effect replays once after the current one finishes.
- Priority when granting: over > start > miss > hit.
- Note tables (tone codes, in order):
  - hit: 20, 24
  - miss: 12, 8, 4
  - start: 12, 16, 19, 24
  - over: 24, 19, 16, 12
- FSM states:
  - IDLE: if any pending bit is set, grant the highest-priority one on the next edge. Load active_id, idx=0, cnt=0; go to PLAY.
  - PLAY: tone=table[active_id][idx], tone_valid=1. cnt counts 0..NOTE_CYCLES-1. On the last count, cnt=0; go to GAP.
  - GAP: tone=0, tone_valid=0. cnt counts 0..GAP_CYCLES-1. On the last count:
    - if idx is the last note: go to IDLE, busy drops on that edge.
    - else: idx+1, back to PLAY.
- Latency: pulse sampled at edge k sets pending at k. PLAY is entered with the first tone at edge k+1, so it is visible in the cycle after k+1. IDLE always costs at least one cycle between effects.
- Effect duration: len*(NOTE_CYCLES+GAP_CYCLES) cycles in PLAY/GAP.
- Simultaneous pulses on the same edge: all latch; they are then played back-to-back in priority order.
- A request arriving on the same edge as a grant is latched and is not lost.
- music_en_out = en_music & ~busy (registered, same-cycle as busy); passes en_music straight through when idle.
- idx: 2 bits. cnt: wide enough for max(NOTE_CYCLES, GAP_CYCLES)-1; no wrap beyond terminal count.

Optional Feature:
Macro: SFX_PREEMPT_EN
- Defined: while in PLAY or GAP with active_id != 3, a pending req_over aborts the current effect on the next edge. active_id becomes 3, idx=0, cnt=0, state PLAY. The aborted effect is discarded (its pending bit is not re-set).
- Not defined: arbitration is strictly non-preemptive; game-over waits until the current effect finishes.

Test Plan:
(All scenarios use NOTE_CYCLES=4, GAP_CYCLES=2.)
1. Reset then single req_hit pulse:
   - tone 20 for 4 cycles, 0 for 2, 24 for 4, 0 for 2.
   - busy high for exactly 12 cycles; music_en_out low during those 12 cycles while en_music=1.
2. req_hit and req_miss in the same cycle:
   - miss sequence 12, 8, 4 plays first, then one IDLE cycle, then hit 20, 24.
   - active_id goes 1 then 0.
3. Three req_hit pulses during one playing hit:
   - exactly one additional hit replays afterwards; total two hit sequences.
4. req_over during the second note of start:
   - without SFX_PREEMPT_EN: start completes (12, 16, 19, 24), then over plays (24, 19, 16, 12).
   - with SFX_PREEMPT_EN: the tone after the current one is 24 with active_id=3 on the next edge.
5. rst asserted asynchronously mid-PLAY of miss:
   - tone=0, busy=0, all pending cleared without a clock edge.
   - after release, stays IDLE with no replay.
6. en_music toggled while idle:
   - music_en_out follows it.
   - with a start request, music_en_out is held 0 through all 24 effect cycles, then restored.
